// File: rtl/memory_unit.sv
// rtl/memory_unit.sv - boot-loaded byte RAM serving CPU requests
module memory_unit #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_W+DATA_W:0] memory_in,
    output logic [DATA_W-1:0]      memory_out,
    input  logic                   load_valid,
    input  logic [DATA_W-1:0]      load_data,
    input  logic                   load_last,
    output logic                   load_ready,
    output logic                   boot_done,
    output logic [ADDR_W:0]        boot_count
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [ADDR_W-1:0] ptr;
    logic              load_xfer;
    logic              load_final;

    assign cpu_we    = memory_in[ADDR_W+DATA_W];
    assign cpu_addr  = memory_in[ADDR_W+DATA_W-1:DATA_W];
    assign cpu_wdata = memory_in[DATA_W-1:0];

    // The load pointer is the low bits of the byte count; the count only
    // reaches DEPTH as the FSM leaves BOOT, so the pointer never wraps in use.
    assign ptr = boot_count[ADDR_W-1:0];

    // Ready is constant in BOOT, so a transfer is simply valid while booting.
    assign load_xfer  = (state == BOOT) && load_valid;
    assign load_final = load_last || (ptr == ADDR_W'(DEPTH - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: leave BOOT on the accepting edge of the final byte
    always_comb begin
        state_nxt = state;
        if (load_xfer && load_final) begin
            state_nxt = RUN;
        end
    end

    // Outputs: handshake/status from state, read data gated until RUN
    always_comb begin
        load_ready = (state == BOOT);
        boot_done  = (state == RUN);
        memory_out = '0;
        if ((state == RUN) && !rst) begin
            memory_out = mem[cpu_addr];
        end
    end

    // Boot byte counter, frozen once in RUN
    always_ff @(posedge clk) begin
        if (rst) begin
            boot_count <= '0;
        end else if (load_xfer) begin
            boot_count <= boot_count + 1'b1;
        end
    end

    // RAM: cleared on reset, filled by the boot stream, then owned by the CPU
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (load_xfer) begin
            mem[ptr] <= load_data;
        end else if ((state == RUN) && cpu_we) begin
            mem[cpu_addr] <= cpu_wdata;
        end
    end

endmodule

// File: doc/memory_unit.md
Name: memory_unit

Overview:
- Byte-wide program/data RAM sitting directly downstream of central_processing_unit. Consumes its 15-bit memory_in request bus and returns memory_out.
- Contains a boot loader FSM. After reset it fills RAM from an external byte stream using a valid/ready handshake.
- Once boot completes it asserts boot_done. Top level holds the CPU idle until then.

Parameters:
- ADDR_W, 6, address width; depth = 2**ADDR_W bytes.
- DATA_W, 8, data width; must equal memory_out width.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- memory_in  input  1+ADDR_W+DATA_W (15)  CPU request: [14]=write enable, [13:8]=address, [7:0]=write data.
- memory_out  output  DATA_W (8)  read data to CPU.
- load_valid  input  1  boot stream byte valid.
- load_data  input  DATA_W  boot stream byte.
- load_last  input  1  marks final boot byte; qualified by load_valid.
- load_ready  output  1  boot loader can accept a byte.
- boot_done  output  1  RAM released to CPU.
- boot_count  output  ADDR_W+1  number of bytes loaded (0..64).

Behaviour:
- Reset (rst=1 at clk edge), one cycle:
  - all 64 locations cleared to 0x00
  - FSM goes to BOOT; load pointer=0; boot_count=0; boot_done=0
  - load_ready=1 from the first cycle after reset
  - memory_out=0x00 during reset and throughout BOOT
- FSM states: BOOT, RUN. No other states; RUN is left only by rst.
- BOOT:
  - load_ready=1.
  - Handshake: a byte transfers on an edge where load_valid=1 and load_ready=1. On transfer, mem[ptr] <= load_data, then ptr and boot_count increment.
  - load_valid=0 stalls indefinitely with no state change.
  - load_data must be held until accepted. It is always accepted next edge, since ready is constant in BOOT.
  - Transition to RUN on the accepting edge when load_last=1, or when ptr=63 (64th byte; ptr does not wrap). Both together give a single transition.
  - load_last with load_valid=0 is ignored.
  - memory_in is ignored entirely in BOOT: CPU writes are dropped, reads return 0x00.
- RUN:
  - load_ready=0 and boot_done=1, both registered and effective the cycle after the final accepting edge.
  - load_valid ignored; boot_count frozen.
  - Reads: memory_out = mem[memory_in[13:8]], combinational (same-cycle) read.
  - Writes: when memory_in[14]=1, mem[memory_in[13:8]] <= memory_in[7:0] at the clk edge.
  - Read-during-write to the same address shows old data until the edge, new data after it.
- Addresses are always in range; no wrap logic is needed beyond natural ADDR_W truncation.
- Reset mid-BOOT or mid-RUN:
  - restarts BOOT from ptr=0 with RAM cleared
  - any handshake in flight on the reset edge is discarded

Test Plan:
- Reset, stream 0x11,0x22,0x33 with load_last on 0x33 -> boot_count=3; boot_done=1 one cycle after third transfer; RUN read addr 1 returns 0x22, addr 3 returns 0x00.
- Stream 64 bytes (value=addr^0xA5) without load_last -> auto RUN after 64th; boot_count=64; load_ready=0; a 65th valid byte is ignored and addr 0 still reads 0xA5.
- In RUN drive memory_in={1,6'd10,8'h5C}, then {0,6'd10,8'h00} -> read before the edge shows old value; after the edge memory_out=0x5C.
- During BOOT drive memory_in write {1,6'd2,8'hFF} -> dropped, memory_out=0x00; after boot with no byte loaded at 2, addr 2 reads 0x00.
- Gap load_valid low for 5 cycles between bytes -> ptr/boot_count hold; subsequent bytes land at consecutive addresses.
- Assert rst after 2 boot bytes, then load 0x77 with load_last -> boot_count=1; addr 0=0x77; addr 1=0x00.
